// File: rtl/pp_tree_pkg.sv
// Shared sizing helpers for the pipelined carry-save reduction tree.
// Row counts per level and level counts are compile-time constants.
package pp_tree_pkg;

  localparam int PP_MAX_LEVELS = 10;

  function automatic int rows_after(input int r);
    return 2 * (r / 3) + r % 3;
  endfunction

  function automatic int num_levels(input int n);
    int r = n;
    int l = 0;
    for (int i = 0; i < PP_MAX_LEVELS; i++)
      if (r > 2) begin
        r = rows_after(r);
        l++;
      end
    return l;
  endfunction

  // rows_after(2) == 2, so levels past the end leave the count unchanged
  function automatic int rows_at(input int n, input int lvl);
    int r = n;
    for (int i = 0; i < PP_MAX_LEVELS; i++)
      if (i < lvl) r = rows_after(r);
    return r;
  endfunction

endpackage

// File: rtl/pp_tree_pipe_csa_row.sv
// Combinational 3:2 row compressor; carry row is pre-shifted, MSB carry dropped.
module csa_row #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry_shifted
);

  logic [W-1:0] maj;

  assign sum           = a ^ b ^ c;
  assign maj           = (a & b) | (a & c) | (b & c);
  assign carry_shifted = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/pp_tree_pipe.sv
// Pipelined CSA reduction tree: N_PP rows -> sum/carry (or a single sum via CPA),
// global-stall valid/ready handshake with a tag riding along each transaction.
module pp_tree_pipe
  import pp_tree_pkg::*;
#(
  parameter int W         = 64,
  parameter int N_PP      = 17,
  parameter int TAG_W     = 8,
  parameter int FINAL_ADD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W*N_PP-1:0]   pp_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        sum_o,
  output logic [W-1:0]        carry_o,
  output logic [TAG_W-1:0]    tag_o
);

  localparam int NL     = num_levels(N_PP);
  localparam int STAGES = NL + ((FINAL_ADD != 0) ? 1 : 0);

  logic                     adv;
  logic [STAGES:0]          vld_pipe;
  logic [TAG_W-1:0]         tag_pipe [STAGES+1];
  logic [NL:0][N_PP-1:0][W-1:0] st_q;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign tag_o     = tag_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i <= STAGES; i++) tag_pipe[i] <= '0;
    end else if (adv) begin
      vld_pipe    <= {vld_pipe[STAGES-1:0], in_valid};
      tag_pipe[0] <= tag_i;
      for (int i = 1; i <= STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Stage 0 registers the raw rows; stage s holds the rows after s levels.
  for (genvar s = 0; s <= NL; s++) begin : g_st
    localparam int R_IN  = (s == 0) ? N_PP : rows_at(N_PP, s - 1);
    localparam int R_OUT = rows_at(N_PP, s);
    localparam int T     = R_IN / 3;

    logic [N_PP-1:0][W-1:0] d;
    logic [N_PP-1:0][W-1:0] q;

    if (s == 0) begin : g_load
      for (genvar k = 0; k < N_PP; k++) begin : g_row
        assign d[k] = pp_i[k*W +: W];
      end
    end else begin : g_cmp
      for (genvar j = 0; j < T; j++) begin : g_csa
        csa_row #(.W(W)) u_csa (
          .a             (st_q[s-1][3*j]),
          .b             (st_q[s-1][3*j+1]),
          .c             (st_q[s-1][3*j+2]),
          .sum           (d[2*j]),
          .carry_shifted (d[2*j+1])
        );
      end
      for (genvar k = 0; k < R_IN - 3*T; k++) begin : g_pass
        assign d[2*T+k] = st_q[s-1][3*T+k];
      end
      for (genvar k = R_OUT; k < N_PP; k++) begin : g_zero
        assign d[k] = '0;
      end
    end

    // Only the stage that drives the outputs needs a reset value.
    always_ff @(posedge clk) begin
      if (rst && s == STAGES) q <= '0;
      else if (adv)           q <= d;
    end

    assign st_q[s] = q;
  end

  if (FINAL_ADD != 0) begin : g_cpa
    logic [W-1:0] sum_q;
    always_ff @(posedge clk) begin
      if (rst)      sum_q <= '0;
      else if (adv) sum_q <= st_q[NL][0] + st_q[NL][1];
    end
    assign sum_o   = sum_q;
    assign carry_o = '0;
  end else begin : g_raw
    assign sum_o   = st_q[NL][0];
    assign carry_o = st_q[NL][1];
  end

endmodule

// File: tb/tb_pp_tree_pipe.sv
// Directed bench for pp_tree_pipe: scoreboarded default config, a FINAL_ADD
// instance and a minimal 3-row instance.
module tb_pp_tree_pipe;

  localparam int W = 64, N = 17, TW = 8, WC = 16, NC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: N=17 W=64 FINAL_ADD=0
  logic            a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
  logic [N*W-1:0]  a_pp = '0;
  logic [TW-1:0]   a_tag = '0, a_tag_o;
  logic [W-1:0]    a_sum, a_carry;

  pp_tree_pipe #(.W(W), .N_PP(N), .TAG_W(TW), .FINAL_ADD(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .pp_i(a_pp), .tag_i(a_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sum_o(a_sum), .carry_o(a_carry), .tag_o(a_tag_o));

  // ---------------- DUT B: N=17 W=64 FINAL_ADD=1
  logic            b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
  logic [N*W-1:0]  b_pp = '0;
  logic [TW-1:0]   b_tag = '0, b_tag_o;
  logic [W-1:0]    b_sum, b_carry;

  pp_tree_pipe #(.W(W), .N_PP(N), .TAG_W(TW), .FINAL_ADD(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .pp_i(b_pp), .tag_i(b_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sum_o(b_sum), .carry_o(b_carry), .tag_o(b_tag_o));

  // ---------------- DUT C: N=3 W=16 FINAL_ADD=0
  logic             c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 1;
  logic [NC*WC-1:0] c_pp = '0;
  logic [TW-1:0]    c_tag = '0, c_tag_o;
  logic [WC-1:0]    c_sum, c_carry;

  pp_tree_pipe #(.W(WC), .N_PP(NC), .TAG_W(TW), .FINAL_ADD(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .pp_i(c_pp), .tag_i(c_tag), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .sum_o(c_sum), .carry_o(c_carry), .tag_o(c_tag_o));

  // ---------------- reference model
  typedef struct { logic [63:0] s; logic [TW-1:0] t; } exp_t;
  exp_t a_q[$], c_q[$];
  exp_t a_e, c_e;
  int   a_pop_cyc[$];
  int   c_pops = 0;
  int   a_acc_cyc = 0;

  function automatic logic [63:0] sum_a(input logic [N*W-1:0] pp);
    logic [63:0] s = '0;
    for (int k = 0; k < N; k++) s += pp[k*W +: W];
    return s;
  endfunction

  function automatic logic [63:0] sum_c(input logic [NC*WC-1:0] pp);
    logic [WC-1:0] s = '0;
    for (int k = 0; k < NC; k++) s += pp[k*WC +: WC];
    return 64'(s);
  endfunction

  function automatic logic [N*W-1:0] rnd_a();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = {$urandom(), $urandom()};
    return r;
  endfunction

  function automatic logic [N*W-1:0] fill_a(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = v;
    return r;
  endfunction

  // Scoreboard consumers: compare whenever a result is taken.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (a_q.size() == 0) chk("a_extra_output", 64'(a_q.size()), 64'd1);
      else begin
        a_e = a_q.pop_front();
        chk("a_invariant", a_sum + a_carry, a_e.s);
        chk("a_tag", 64'(a_tag_o), 64'(a_e.t));
        chk("a_carry_lsb", 64'(a_carry[0]), 64'd0);
        a_pop_cyc.push_back(cyc);
      end
    end
    if (!rst && c_out_valid && c_out_ready) begin
      if (c_q.size() == 0) chk("c_extra_output", 64'(c_q.size()), 64'd1);
      else begin
        c_e = c_q.pop_front();
        chk("c_invariant", 64'(WC'(c_sum + c_carry)), c_e.s);
        chk("c_tag", 64'(c_tag_o), 64'(c_e.t));
        c_pops++;
      end
    end
  end

  task automatic send_a(input logic [N*W-1:0] pp, input logic [TW-1:0] t);
    int n = 0;
    a_pp = pp; a_tag = t; a_in_valid = 1;
    @(negedge clk);
    while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("a_send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    if (n < 100) a_q.push_back('{s: sum_a(pp), t: t});
    #1;
    a_in_valid = 0;
    a_acc_cyc  = cyc;
  endtask

  task automatic send_c(input logic [NC*WC-1:0] pp, input logic [TW-1:0] t);
    int n = 0;
    c_pp = pp; c_tag = t; c_in_valid = 1;
    @(negedge clk);
    while (!c_in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("c_send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    if (n < 100) c_q.push_back('{s: sum_c(pp), t: t});
    #1;
    c_in_valid = 0;
  endtask

  task automatic lat_a(output int lat);
    lat = 0;
    while (!a_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic drain_a(input string tag);
    int n = 0;
    while (a_q.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk(tag, 64'(a_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0, acc0, n;
    logic [W-1:0] s0, c0;
    logic [TW-1:0] t0;

    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset state
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_sum", a_sum, 64'd0);
    chk("rst_carry", a_carry, 64'd0);
    chk("rst_tag", 64'(a_tag_o), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_sum", b_sum, 64'd0);

    // all ones, latency 6
    send_a(fill_a(64'd1), 8'h5A);
    lat_a(lat);
    chk("a_lat_ones", 64'(lat), 64'd6);
    chk("a_ones_sum", a_sum + a_carry, 64'd17);
    @(posedge clk); #1;

    // wrap-around
    send_a(fill_a('1), 8'hC3);
    lat_a(lat);
    chk("a_lat_wrap", 64'(lat), 64'd6);
    chk("a_wrap_sum", a_sum + a_carry, 64'hFFFF_FFFF_FFFF_FFEF);
    @(posedge clk); #1;

    // FINAL_ADD instance: single sum, zero carry, latency 7
    b_pp = fill_a('1); b_tag = 8'h77; b_in_valid = 1;
    @(negedge clk);
    chk("b_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;
    b_in_valid = 0;
    lat = 0;
    while (!b_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("b_lat", 64'(lat), 64'd7);
    chk("b_sum", b_sum, 64'hFFFF_FFFF_FFFF_FFEF);
    chk("b_carry", b_carry, 64'd0);
    chk("b_tag", 64'(b_tag_o), 64'h77);
    @(posedge clk); #1;

    // back-to-back random, one per cycle each way
    drain_a("a_pre_b2b_drain");
    p0 = a_pop_cyc.size();
    send_a(rnd_a(), 8'd0);
    acc0 = a_acc_cyc;
    for (int i = 1; i < 100; i++) send_a(rnd_a(), 8'(i));
    chk("a_b2b_accept_span", 64'(a_acc_cyc - acc0), 64'd99);
    drain_a("a_b2b_drain");
    chk("a_b2b_count", 64'(a_pop_cyc.size() - p0), 64'd100);
    if (a_pop_cyc.size() >= p0 + 100)
      chk("a_b2b_out_span", 64'(a_pop_cyc[p0+99] - a_pop_cyc[p0]), 64'd99);

    // backpressure: stall 5 cycles with results queued
    p0 = a_pop_cyc.size();
    for (int i = 0; i < 4; i++) send_a(rnd_a(), 8'(8'hB0 + i));
    n = 0;
    while (!a_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    a_out_ready = 0;
    s0 = a_sum; c0 = a_carry; t0 = a_tag_o;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(a_out_valid), 64'd1);
      chk("bp_in_ready", 64'(a_in_ready), 64'd0);
      chk("bp_sum_stable", a_sum, s0);
      chk("bp_carry_stable", a_carry, c0);
      chk("bp_tag_stable", 64'(a_tag_o), 64'(t0));
    end
    a_out_ready = 1;
    drain_a("bp_drain");
    chk("bp_count", 64'(a_pop_cyc.size() - p0), 64'd4);

    // reset mid-flight: 4 in flight, input presented during reset is dropped
    for (int i = 0; i < 4; i++) send_a(rnd_a(), 8'(8'hD0 + i));
    rst = 1; a_in_valid = 1; a_pp = rnd_a(); a_tag = 8'hEE;
    @(posedge clk); #1;
    rst = 0; a_in_valid = 0;
    a_q.delete();
    chk("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
    repeat (10) begin
      chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
      @(posedge clk); #1;
    end
    send_a(rnd_a(), 8'h42);
    lat_a(lat);
    chk("mid_rst_lat", 64'(lat), 64'd6);
    @(posedge clk); #1;
    drain_a("mid_rst_drain");

    // 3-row instance: single level, latency 1, then 50 random vectors
    send_c({16'h0003, 16'hFFFF, 16'h1234}, 8'h11);
    n = 0;
    while (!c_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("c_lat", 64'(n), 64'd1);
    chk("c_sum", 64'(WC'(c_sum + c_carry)), 64'h1236);
    for (int i = 0; i < 50; i++) send_c({16'($urandom()), 16'($urandom()), 16'($urandom())}, 8'(i));
    n = 0;
    while (c_q.size() > 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("c_drain", 64'(c_q.size()), 64'd0);
    chk("c_count", 64'(c_pops), 64'd51);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
